vga_vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two users.
- The display pixel fetch is driven by the column/row/active outputs of vga_controller.
- Host writes come through a valid/ready port with a one-entry holding buffer.
- The display always wins during active video. Host writes drain during blanking. The block returns a registered RGB pixel aligned to a fixed pipeline latency.

---
 rtl/vga_vram_arbiter_if.sv | 19 +
 rtl/vga_vram_arbiter.sv | 150 +++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Host write port of the VRAM arbiter: a valid/ready write handshake carrying
// a tile address and an RGB444 pixel value.
//   valid  host -> arbiter  write request
//   ready  arbiter -> host  write accepted when valid && ready
//   addr   host -> arbiter  tile address
//   data   host -> arbiter  pixel data
// master = host side, slave = arbiter side.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous video RAM between the display pixel
// fetch and host writes. The display owns the RAM during active video; a
// one-entry host buffer drains during blanking. Returns a registered pixel
// three clocks after the display inputs are sampled.
// Ports:
//   clk_i, rst_ni            pixel clock, async active-low reset
//   disp_active_i, xcol_i,
//   yrow_i                   raster position from the VGA timing generator
//   host                     host write port (valid/ready, addr, data)
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_wdata_o,
//   mem_rdata_i              single-port RAM bus (1-cycle read latency)
//   rgb_o, rgb_valid_o       pixel to DAC and its active flag
//   err_o                    sticky: out-of-range host write dropped
module vga_vram_arbiter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              disp_active_i,
  input  logic [10:0]       xcol_i,
  input  logic [10:0]       yrow_i,
  vga_vram_arbiter_if.slave host,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rgb_o,
  output logic              rgb_valid_o,
  output logic              err_o
);

  localparam int          TILES_X    = H_ACTIVE >> SCALE_SHIFT;
  localparam int          FB_DEPTH   = TILES_X * (V_ACTIVE >> SCALE_SHIFT);
  localparam logic [31:0] FB_DEPTH_U = 32'(FB_DEPTH);
  localparam int          TW         = 22;

  // Slot owning the RAM access registered at the next edge.
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_HOST} slot_e;

  slot_e             slot;
  logic [ADDR_W-1:0] tile_addr;
  logic              buf_in_range;

  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              act_s1_q, act_s2_q;
  logic [DATA_W-1:0] rgb_q;
  logic              rgb_valid_q;

  // Full-width product, truncated to the RAM address width.
  assign tile_addr = ADDR_W'(TW'(yrow_i >> SCALE_SHIFT) * TW'(TILES_X)
                             + TW'(xcol_i >> SCALE_SHIFT));

  assign buf_in_range = 32'(buf_addr_q) < FB_DEPTH_U;
  assign host.ready   = !buf_full_q;

  always_comb begin
    slot = SLOT_IDLE;
    if (disp_active_i)   slot = SLOT_DISP;
    else if (buf_full_q) slot = SLOT_HOST;
  end

  always_comb begin
    buf_full_d  = buf_full_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    case (slot)
      SLOT_DISP: begin
        mem_en_d   = 1'b1;
        mem_addr_d = tile_addr;
      end
      SLOT_HOST: begin
        // An out-of-range write still frees the buffer but never touches the RAM.
        buf_full_d = 1'b0;
        if (buf_in_range) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = buf_addr_q;
          mem_wdata_d = buf_data_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    // Accept only into an empty buffer, so accept and drain never coincide.
    if (host.valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_addr_d = host.addr;
      buf_data_d = host.data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_full_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      act_s1_q    <= 1'b0;
      act_s2_q    <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      act_s1_q    <= (slot == SLOT_DISP);
      // act_s2 lines up with the RAM's one-cycle read latency.
      act_s2_q    <= act_s1_q;
      rgb_q       <= act_s2_q ? mem_rdata_i : '0;
      rgb_valid_q <= act_s2_q;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign rgb_o       = rgb_q;
  assign rgb_valid_o = rgb_valid_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 12;
  localparam int FB_DEPTH = 4800;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_active;
  logic [10:0]       xcol, yrow;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, rgb;
  logic              rgb_valid, err;

  always #5 clk = ~clk;

  vga_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_if ();

  vga_vram_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .disp_active_i(disp_active),
    .xcol_i(xcol), .yrow_i(yrow), .host(host_if),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .rgb_o(rgb), .rgb_valid_o(rgb_valid), .err_o(err)
  );

  // Background image: unwritten locations read back a fixed pattern.
  function automatic logic [11:0] pat(input int a);
    int t;
    t = (a * 29) ^ 'h5A5;
    return 12'(t);
  endfunction

  function automatic int tile(input int x, input int y);
    return (y / 8) * 80 + x / 8;
  endfunction

  // RAM model
  logic [11:0]       ram     [0:8191];
  logic              written [0:8191];
  logic              ram_clr;
  logic [ADDR_W-1:0] ovr_addr;
  logic [11:0]       ovr_data;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 8192; i++) written[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else if (mem_addr == ovr_addr) mem_rdata <= ovr_data;
      else if (written[mem_addr]) mem_rdata <= ram[mem_addr];
      else mem_rdata <= pat(int'(mem_addr));
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    int          exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;
  vec_t vecs[6];

  typedef struct packed {
    logic        v;
    logic [11:0] rgb;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // reference-model state for the sweep
  logic        hb_full, was_full, err_m, act, e_en, e_we;
  logic [12:0] hb_addr;
  logic [11:0] hb_data;
  int          e_addr, e_wdata, yv, vcount, wr_dut, wr_mod;

  initial begin
    disp_active   = 1'b0;
    xcol          = '0;
    yrow          = '0;
    host_if.valid = 1'b0;
    host_if.addr  = '0;
    host_if.data  = '0;
    ram_clr       = 1'b0;
    ovr_addr      = 13'h1FFF;
    ovr_data      = '0;
    rst_n         = 1'b0;

    // 1: reset
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_rgb_valid", 32'(rgb_valid), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(host_if.ready), 1);

    // 2: display fetch vectors
    ovr_addr = 13'd82;
    ovr_data = 12'hABC;
    vecs[0] = '{11'd17,  11'd9,   82,   12'hABC};
    vecs[1] = '{11'd0,   11'd0,   0,    pat(0)};
    vecs[2] = '{11'd639, 11'd479, 4799, pat(4799)};
    vecs[3] = '{11'd8,   11'd8,   81,   pat(81)};
    vecs[4] = '{11'd7,   11'd15,  80,   pat(80)};
    vecs[5] = '{11'd320, 11'd240, 2440, pat(2440)};
    for (int i = 0; i < 6; i++) begin
      disp_active = 1'b1;
      xcol = vecs[i].x;
      yrow = vecs[i].y;
      tick();
      chk("disp_en", 32'(mem_en), 1);
      chk("disp_we", 32'(mem_we), 0);
      chk("disp_addr", 32'(mem_addr), vecs[i].exp_addr);
      disp_active = 1'b0;
      tick();
      tick();
      chk("disp_rgb", 32'(rgb), 32'(vecs[i].exp_rgb));
      chk("disp_rgb_valid", 32'(rgb_valid), 1);
      tick();
      chk("blank_rgb", 32'(rgb), 0);
      chk("blank_rgb_valid", 32'(rgb_valid), 0);
    end
    ovr_addr = 13'h1FFF;

    // 3: host write during blanking
    host_if.valid = 1'b1;
    host_if.addr  = 13'd100;
    host_if.data  = 12'h0F0;
    chk("h3_ready_before", 32'(host_if.ready), 1);
    tick();
    host_if.valid = 1'b0;
    chk("h3_ready_low", 32'(host_if.ready), 0);
    chk("h3_no_we_yet", 32'(mem_we), 0);
    tick();
    chk("h3_en", 32'(mem_en), 1);
    chk("h3_we", 32'(mem_we), 1);
    chk("h3_addr", 32'(mem_addr), 100);
    chk("h3_wdata", 32'(mem_wdata), 'h0F0);
    chk("h3_ready_back", 32'(host_if.ready), 1);
    tick();
    chk("h3_we_done", 32'(mem_we), 0);
    chk("h3_en_done", 32'(mem_en), 0);
    chk("h3_ram", 32'(ram[100]), 'h0F0);

    // 4: host write stalled by active video
    disp_active   = 1'b1;
    xcol          = 11'd40;
    yrow          = 11'd40;
    host_if.valid = 1'b1;
    host_if.addr  = 13'd200;
    host_if.data  = 12'h123;
    tick();
    host_if.valid = 1'b0;
    chk("h4_ready_low", 32'(host_if.ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("h4_stall_we", 32'(mem_we), 0);
      chk("h4_stall_ready", 32'(host_if.ready), 0);
    end
    disp_active = 1'b0;
    tick();
    chk("h4_we", 32'(mem_we), 1);
    chk("h4_addr", 32'(mem_addr), 200);
    chk("h4_wdata", 32'(mem_wdata), 'h123);
    chk("h4_ready_back", 32'(host_if.ready), 1);

    // 5: out-of-range write, then last valid address
    host_if.valid = 1'b1;
    host_if.addr  = 13'd4800;
    host_if.data  = 12'h777;
    tick();
    host_if.valid = 1'b0;
    chk("h5_ready_low", 32'(host_if.ready), 0);
    tick();
    chk("h5_oor_en", 32'(mem_en), 0);
    chk("h5_oor_we", 32'(mem_we), 0);
    chk("h5_err", 32'(err), 1);
    chk("h5_ready_back", 32'(host_if.ready), 1);
    tick();
    tick();
    chk("h5_err_sticky", 32'(err), 1);
    host_if.valid = 1'b1;
    host_if.addr  = 13'd4799;
    host_if.data  = 12'h321;
    tick();
    host_if.valid = 1'b0;
    tick();
    chk("h5_last_en", 32'(mem_en), 1);
    chk("h5_last_we", 32'(mem_we), 1);
    chk("h5_last_addr", 32'(mem_addr), 4799);
    chk("h5_last_wdata", 32'(mem_wdata), 'h321);
    chk("h5_err_still", 32'(err), 1);

    // 6: randomized raster sweep against the reference model
    rst_n   = 1'b0;
    ram_clr = 1'b1;
    tick();
    ram_clr = 1'b0;
    chk("sweep_rst_err", 32'(err), 0);
    rst_n = 1'b1;
    repeat (4) tick();
    hb_full = 1'b0;
    hb_addr = '0;
    hb_data = '0;
    err_m   = 1'b0;
    vcount  = 0;
    wr_dut  = 0;
    wr_mod  = 0;
    exp_q   = {};
    exp_q.push_back('{v: 1'b0, rgb: 12'h000});
    exp_q.push_back('{v: 1'b0, rgb: 12'h000});
    for (int li = 0; li < 60; li++) begin
      yv = (li < 55) ? 470 + li : li - 55;
      for (int x = 0; x < 800; x++) begin
        act           = (x < 640) && (yv < 480);
        disp_active   = act;
        xcol          = 11'(x);
        yrow          = 11'(yv);
        host_if.valid = ($urandom_range(0, 3) != 0);
        host_if.addr  = ($urandom_range(0, 15) == 0) ? 13'($urandom_range(FB_DEPTH, 8191))
                                                     : 13'($urandom_range(1000, 4000));
        host_if.data  = 12'($urandom);
        chk("sw_ready", 32'(host_if.ready), 32'(!hb_full));
        was_full = hb_full;
        e_en     = 1'b0;
        e_we     = 1'b0;
        e_addr   = 0;
        e_wdata  = 0;
        if (act) begin
          e_en   = 1'b1;
          e_addr = tile(x, yv);
        end else if (hb_full) begin
          hb_full = 1'b0;
          if (int'(hb_addr) < FB_DEPTH) begin
            e_en    = 1'b1;
            e_we    = 1'b1;
            e_addr  = int'(hb_addr);
            e_wdata = int'(hb_data);
            wr_mod++;
          end else begin
            err_m = 1'b1;
          end
        end
        if (!was_full && host_if.valid) begin
          hb_full = 1'b1;
          hb_addr = host_if.addr;
          hb_data = host_if.data;
        end
        exp_q.push_back('{v: act, rgb: act ? pat(tile(x, yv)) : 12'h000});
        tick();
        chk("sw_en", 32'(mem_en), 32'(e_en));
        chk("sw_we", 32'(mem_we), 32'(e_we));
        if (e_en) chk("sw_addr", 32'(mem_addr), e_addr);
        if (e_we) chk("sw_wdata", 32'(mem_wdata), e_wdata);
        chk("sw_err", 32'(err), 32'(err_m));
        e = exp_q.pop_front();
        chk("sw_rgb_valid", 32'(rgb_valid), 32'(e.v));
        chk("sw_rgb", 32'(rgb), 32'(e.rgb));
        if (rgb_valid) vcount++;
        if (mem_we) wr_dut++;
      end
    end
    chk("sw_valid_count", vcount, 15 * 640);
    chk("sw_write_count", wr_dut, wr_mod);

    // mid-line asynchronous reset
    host_if.valid = 1'b0;
    disp_active   = 1'b1;
    yrow          = 11'd100;
    for (int i = 0; i < 6; i++) begin
      xcol = 11'(i);
      tick();
    end
    chk("mid_valid_before", 32'(rgb_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_valid_async", 32'(rgb_valid), 0);
    chk("mid_rgb_async", 32'(rgb), 0);
    chk("mid_en_async", 32'(mem_en), 0);
    disp_active = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mid_ready", 32'(host_if.ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
